comp_serial_32: RTL
===================

COMP_SERIAL_32 -- requirements
Module: comp_serial_32

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a multiple of 8, 8..64 supported; N = WIDTH/8 slices.
REQ-002 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand pair A/B presented.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: a  input  WIDTH  operand A, unsigned.
REQ-007 Port: b  input  WIDTH  operand B, unsigned.
REQ-008 Port: out_valid  output  1  result eq/gt valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: eq  output  1  A == B.
REQ-011 Port: gt  output  1  A > B.
REQ-012 Port: busy  output  1  comparison in progress (state RUN).

Function
REQ-013 The block SHALL contain exactly one instance of the team's 8-bit cascadable comparator slice comp_8 and time-share it across all N byte slices.
REQ-014 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE, busy = 1 only in RUN, out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid && in_ready at an edge, latch a and b, set eq_acc = 1, gt_acc = 0, idx = N-1, go to RUN.
REQ-016 RUN: each cycle drive the slice with byte idx of the latched A and B, cascade inputs EQ1 = eq_acc, GT1 = gt_acc; at the edge register EQ0/GT0 into eq_acc/gt_acc.
REQ-017 RUN: if idx == 0 at the edge, go to DONE; otherwise decrement idx (MSB-first order, byte N-1 down to byte 0).
REQ-018 Latency without early exit: out_valid SHALL rise exactly N edges after the accept edge (4 for WIDTH = 32).
REQ-019 DONE: eq = eq_acc, gt = gt_acc, held stable while out_valid && !out_ready; eq and gt SHALL never both be 1.
REQ-020 DONE: on out_ready at an edge, go to IDLE; the next operand pair SHALL NOT be accepted on that same edge (min. issue interval N+2 cycles).
REQ-021 eq and gt SHALL read 0 outside DONE.
REQ-022 in_valid while not in IDLE SHALL be ignored; a and b SHALL be sampled only on the accept edge.
REQ-023 Operands SHALL NOT be treated as signed; 0xFFFFFFFF > 0x00000000.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, in_ready = 1 after release, out_valid = 0, busy = 0, eq = 0, gt = 0, eq_acc = 1, gt_acc = 0, idx = N-1.
REQ-025 Reset asserted during RUN or DONE SHALL discard the comparison in progress; no result is produced for it.
REQ-026 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro COMP_SERIAL_EARLY_EXIT_EN, when defined: in RUN, if the slice EQ0 output is 0 at the edge, go to DONE immediately regardless of idx (result is final once a byte differs); latency = 1 + index distance from byte N-1 to first differing byte, min 1, max N.
REQ-028 Without COMP_SERIAL_EARLY_EXIT_EN: RUN SHALL always last exactly N cycles; results SHALL be identical in both builds, only latency differs.

Verification
REQ-029 a = 0x12345678, b = 0x12345678, out_ready = 1 -> out_valid 4 edges after accept, eq = 1, gt = 0; both builds.
REQ-030 a = 0x80000000, b = 0x7FFFFFFF -> eq = 0, gt = 1; latency 1 with COMP_SERIAL_EARLY_EXIT_EN, 4 without.
REQ-031 a = 0x00000010, b = 0x00000011 -> eq = 0, gt = 0, latency 4 in both builds (difference in byte 0).
REQ-032 Back-pressure: out_ready = 0 for 10 cycles in DONE -> out_valid, eq, gt stable, in_ready = 0, new in_valid ignored; out_ready = 1 -> IDLE next edge.
REQ-033 reset_n pulsed low during RUN of a = 0xFF000000, b = 0 -> all outputs 0 immediately, in_ready = 1 after release, no out_valid for the aborted pair; next pair a = 5, b = 3 yields gt = 1.
REQ-034 Randomized 1000 pairs including equal-prefix cases vs. a reference model (A == B, A > B) -> zero mismatches, eq && gt never observed.

Source files
------------

// File: rtl/comp_serial_32_if.sv
// Operand/result handshake bundle for comp_serial_32.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready, a, b       operand pair handshake (A/B unsigned)
//   out_valid, out_ready, eq, gt   result handshake (eq = A==B, gt = A>B)
//   busy                           comparison in progress
interface comp_serial_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             busy;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, gt, busy
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, gt, busy
  );
endinterface

// File: rtl/comp_serial_32.sv
// Serial unsigned magnitude comparator: one 8-bit cascadable slice walked MSB byte first.
// Latency: WIDTH/8 edges from accept to out_valid (1..WIDTH/8 with COMP_SERIAL_EARLY_EXIT_EN).
// Backpressure: one pair in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports: clock, reset_n (async active-low), bus (comp_serial_32_if.slave: in_valid/in_ready/a/b,
//        out_valid/out_ready/eq/gt, busy).
// Optional build macro: COMP_SERIAL_EARLY_EXIT_EN -- leave RUN as soon as a byte differs.

// 8-bit cascadable comparator slice. eq1/gt1 carry the verdict of the more
// significant bytes; a lower byte only matters while everything above is equal.
module comp_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       eq1,
  input  logic       gt1,
  output logic       eq0,
  output logic       gt0
);
  always_comb begin
    eq0 = eq1 & (a == b);
    gt0 = gt1 | (eq1 & (a > b));
  end
endmodule

module comp_serial_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  comp_serial_32_if.slave      bus
);
  localparam int N     = WIDTH / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             eq_acc_q, eq_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [7:0] slice_a;
  logic [7:0] slice_b;
  logic       slice_eq;
  logic       slice_gt;

  // The single shared slice; the byte lane is chosen by idx_q.
  assign slice_a = a_q[idx_q*8 +: 8];
  assign slice_b = b_q[idx_q*8 +: 8];

  comp_8 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .eq1 (eq_acc_q),
    .gt1 (gt_acc_q),
    .eq0 (slice_eq),
    .gt0 (slice_gt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      eq_acc_q <= 1'b1;
      gt_acc_q <= 1'b0;
      idx_q    <= IDX_TOP;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    idx_d    = idx_q;

    case (state_q)
      IDLE: begin
        // Operands are only sampled here, so the producer may change a/b freely otherwise.
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          eq_acc_d = 1'b1;
          gt_acc_d = 1'b0;
          idx_d    = IDX_TOP;
          state_d  = RUN;
        end
      end
      RUN: begin
        eq_acc_d = slice_eq;
        gt_acc_d = slice_gt;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        // Once a byte differs the lower bytes cannot change the verdict.
        if (!slice_eq) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        // Returning to IDLE first means a new pair is never taken on the release edge.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state; eq/gt are gated so they read 0 outside DONE.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == RUN);
    bus.out_valid = (state_q == DONE);
    bus.eq        = (state_q == DONE) & eq_acc_q;
    bus.gt        = (state_q == DONE) & gt_acc_q & ~eq_acc_q;
  end
endmodule
